pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 97 +++++++++
 tb/tb_pipe_stage_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS inter-stage register: valid bit, stall/hold, flush-to-bubble, stall watchdog.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_reg #(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_DATA  = 3,
    parameter int RWIDTH    = 5,
    parameter int NUM_REGS  = 3,
    parameter int MAX_STALL = 15,
    parameter int CNT_W     = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic                         Flush,
    input  logic                         In_Valid,
    input  logic [CTRL_W-1:0]            In_Ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]   In_Data,
    input  logic [NUM_REGS*RWIDTH-1:0]   In_Regs,
    output logic                         Out_Valid,
    output logic [CTRL_W-1:0]            Out_Ctrl,
    output logic [NUM_DATA*DATA_W-1:0]   Out_Data,
    output logic [NUM_REGS*RWIDTH-1:0]   Out_Regs,
    output logic [CNT_W-1:0]             Stall_Cnt,
    output logic                         Stall_Timeout
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                  Perf_Stalls,
    output logic [15:0]                  Perf_Flushes
`endif
);

    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] cnt_next;
    logic             hold;

    // A flush always wins over a stall, so only a pure stall holds the stage.
    assign hold = Stall && !Flush;

    always_comb begin
        cnt_next = Stall_Cnt;
        if (Stall_Cnt != CNT_SAT) begin
            cnt_next = Stall_Cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Out_Valid     <= 1'b0;
            Out_Ctrl      <= '0;
            Out_Data      <= '0;
            Out_Regs      <= '0;
            Stall_Cnt     <= '0;
            Stall_Timeout <= 1'b0;
        end else begin
            Stall_Timeout <= 1'b0;
            if (Flush) begin
                // Data still moves on a bubble; zero control makes it inert downstream.
                Out_Valid <= 1'b0;
                Out_Ctrl  <= '0;
                Out_Data  <= In_Data;
                Out_Regs  <= In_Regs;
                Stall_Cnt <= '0;
            end else if (hold) begin
                Stall_Cnt     <= cnt_next;
                Stall_Timeout <= (cnt_next == STALL_LIMIT) && (Stall_Cnt != STALL_LIMIT);
            end else begin
                Out_Valid <= In_Valid;
                Out_Ctrl  <= In_Valid ? In_Ctrl : '0;
                Out_Data  <= In_Data;
                Out_Regs  <= In_Regs;
                Stall_Cnt <= '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Perf_Stalls  <= '0;
            Perf_Flushes <= '0;
        end else begin
            if (hold && (Perf_Stalls != 16'hFFFF)) begin
                Perf_Stalls <= Perf_Stalls + 16'd1;
            end
            if (Flush && (Perf_Flushes != 16'hFFFF)) begin
                Perf_Flushes <= Perf_Flushes + 16'd1;
            end
        end
    end
`else
    // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a spec-level model pushes expected
// stage contents on each driven cycle; they are popped and compared after the edge.
module tb_pipe_stage_reg;

    localparam int CTRL_W    = 8;
    localparam int DATA_W    = 32;
    localparam int NUM_DATA  = 3;
    localparam int RWIDTH    = 5;
    localparam int NUM_REGS  = 3;
    localparam int MAX_STALL = 15;
    localparam int CNT_W     = 4;
    localparam int DW        = NUM_DATA * DATA_W;
    localparam int RW        = NUM_REGS * RWIDTH;
    localparam int EXP_W     = 1 + CTRL_W + DW + RW + CNT_W + 1;

    logic              Clock;
    logic              Reset;
    logic              Stall;
    logic              Flush;
    logic              In_Valid;
    logic [CTRL_W-1:0] In_Ctrl;
    logic [DW-1:0]     In_Data;
    logic [RW-1:0]     In_Regs;
    logic              Out_Valid;
    logic [CTRL_W-1:0] Out_Ctrl;
    logic [DW-1:0]     Out_Data;
    logic [RW-1:0]     Out_Regs;
    logic [CNT_W-1:0]  Stall_Cnt;
    logic              Stall_Timeout;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]       Perf_Stalls;
    logic [15:0]       Perf_Flushes;
`endif

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RWIDTH(RWIDTH),
        .NUM_REGS(NUM_REGS), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ctrl(In_Ctrl), .In_Data(In_Data), .In_Regs(In_Regs),
        .Out_Valid(Out_Valid), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data), .Out_Regs(Out_Regs),
        .Stall_Cnt(Stall_Cnt), .Stall_Timeout(Stall_Timeout)
`ifdef PIPE_STAGE_PERF_EN
        , .Perf_Stalls(Perf_Stalls), .Perf_Flushes(Perf_Flushes)
`endif
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Scoreboard and reference model state
    logic [EXP_W-1:0]  exp_q[$];
    int                n_cmp;
    int                n_bad;
    int                pulses;
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DW-1:0]     m_data;
    logic [RW-1:0]     m_regs;
    logic [CNT_W-1:0]  m_cnt;
    logic              m_to;
    logic [15:0]       m_pstall;
    logic [15:0]       m_pflush;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_ctrl   = '0;
        m_data   = '0;
        m_regs   = '0;
        m_cnt    = '0;
        m_to     = 1'b0;
        m_pstall = '0;
        m_pflush = '0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic v,
                              input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                              input logic [RW-1:0] r);
        logic [CNT_W-1:0] old_cnt;
        old_cnt = m_cnt;
        m_to = 1'b0;
        if (f) begin
            m_valid = 1'b0;
            m_ctrl  = '0;
            m_data  = d;
            m_regs  = r;
            m_cnt   = '0;
            if (m_pflush != 16'hFFFF) m_pflush = m_pflush + 16'd1;
        end else if (s) begin
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            m_to = (int'(m_cnt) == MAX_STALL) && (int'(old_cnt) != MAX_STALL);
            if (m_pstall != 16'hFFFF) m_pstall = m_pstall + 16'd1;
        end else begin
            m_valid = v;
            m_ctrl  = v ? c : '0;
            m_data  = d;
            m_regs  = r;
            m_cnt   = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 128'(Out_Valid), 128'(0));
        check_eq({tag, "_ctrl"}, 128'(Out_Ctrl), 128'(0));
        check_eq({tag, "_data"}, 128'(Out_Data), 128'(0));
        check_eq({tag, "_regs"}, 128'(Out_Regs), 128'(0));
        check_eq({tag, "_cnt"}, 128'(Stall_Cnt), 128'(0));
        check_eq({tag, "_timeout"}, 128'(Stall_Timeout), 128'(0));
`ifdef PIPE_STAGE_PERF_EN
        check_eq({tag, "_perf_stalls"}, 128'(Perf_Stalls), 128'(0));
        check_eq({tag, "_perf_flushes"}, 128'(Perf_Flushes), 128'(0));
`endif
    endtask

    // Driver: called just after a falling edge; asserts Reset between edges.
    task automatic mid_cycle_reset();
        Reset = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Driver: applies one cycle of stimulus, pushes the expectation, checks it after the edge.
    task automatic step(input string tag, input logic s, input logic f, input logic v,
                        input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                        input logic [RW-1:0] r);
        logic [EXP_W-1:0] e;
        Stall    = s;
        Flush    = f;
        In_Valid = v;
        In_Ctrl  = c;
        In_Data  = d;
        In_Regs  = r;
        model_step(s, f, v, c, d, r);
        exp_q.push_back({m_valid, m_ctrl, m_data, m_regs, m_cnt, m_to});
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_valid"}, 128'(Out_Valid), 128'(e[EXP_W-1]));
        check_eq({tag, "_ctrl"}, 128'(Out_Ctrl), 128'(e[EXP_W-2 -: CTRL_W]));
        check_eq({tag, "_data"}, 128'(Out_Data), 128'(e[EXP_W-2-CTRL_W -: DW]));
        check_eq({tag, "_regs"}, 128'(Out_Regs), 128'(e[CNT_W+1 +: RW]));
        check_eq({tag, "_cnt"}, 128'(Stall_Cnt), 128'(e[1 +: CNT_W]));
        check_eq({tag, "_timeout"}, 128'(Stall_Timeout), 128'(e[0]));
`ifdef PIPE_STAGE_PERF_EN
        check_eq({tag, "_perf_stalls"}, 128'(Perf_Stalls), 128'(m_pstall));
        check_eq({tag, "_perf_flushes"}, 128'(Perf_Flushes), 128'(m_pflush));
`endif
        if (Stall_Timeout) pulses++;
        @(negedge Clock);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [RW-1:0] rnd_regs();
        return RW'($urandom());
    endfunction

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        pulses = 0;
        Reset    = 1'b1;
        Stall    = 1'b0;
        Flush    = 1'b0;
        In_Valid = 1'b0;
        In_Ctrl  = '0;
        In_Data  = '0;
        In_Regs  = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_zero("por");
        @(negedge Clock);
        Reset = 1'b0;

        // Reset asserted between edges while holding a live instruction
        step("load_a5", 0, 0, 1, 8'hA5, rnd_data(), rnd_regs());
        mid_cycle_reset();

        // Plain load
        step("load_3c", 0, 0, 1, 8'h3C, {32'h33, 32'h22, 32'h11}, {5'd3, 5'd2, 5'd1});

        // Flush wins over stall; data still passes
        step("stall_pre", 1, 0, 1, 8'h77, rnd_data(), rnd_regs());
        step("flush_stall", 1, 1, 1, 8'h3C, {32'h0, 32'h0, 32'hDEAD}, rnd_regs());
        check_eq("flush_word0", 128'(Out_Data[DATA_W-1:0]), 128'(32'hDEAD));

        // Stall hold for three edges with changing inputs, then release
        step("load_hold", 0, 0, 1, 8'h3C, {32'h33, 32'h22, 32'h11}, {5'd3, 5'd2, 5'd1});
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1, 0, 1, 8'($urandom()), rnd_data(), rnd_regs());
            check_eq("stall_cnt_seq", 128'(Stall_Cnt), 128'(i + 1));
        end
        step("release", 0, 0, 1, 8'h5A, rnd_data(), rnd_regs());

        // Invalid slot never carries control
        step("invalid_load", 0, 0, 0, 8'hFF, rnd_data(), rnd_regs());

        // Watchdog from a clean reset: 20 stall edges, one pulse, counter saturates
        mid_cycle_reset();
        step("wd_load", 0, 0, 1, 8'h42, rnd_data(), rnd_regs());
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step("wd_stall", 1, 0, 1, 8'($urandom()), rnd_data(), rnd_regs());
            check_eq("wd_pulse_at_15", 128'(Stall_Timeout), 128'(i == 14));
        end
        check_eq("wd_pulse_count", 128'(pulses), 128'(1));
        check_eq("wd_cnt_sat", 128'(Stall_Cnt), 128'(15));
`ifdef PIPE_STAGE_PERF_EN
        check_eq("perf_stalls_20", 128'(Perf_Stalls), 128'(20));
`endif

        // Stall with a bubble still counts; re-fire only after the count clears
        step("bubble", 0, 0, 0, 8'h99, rnd_data(), rnd_regs());
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step("bubble_stall", 1, 0, 0, 8'($urandom()), rnd_data(), rnd_regs());
        end
        check_eq("refire_count", 128'(pulses), 128'(1));

        // Random traffic with long stall runs
        for (int i = 0; i < 300; i++) begin
            step("rand", $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, 8'($urandom()), rnd_data(), rnd_regs());
        end

        check_eq("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
